// File: rtl/lin_resp_hdr_rx_if.sv
// LIN header receiver bus: serial line in, decoded header results out.
// Pulse semantics: pid_valid, sync_err, frame_err and parity_err are
// single-cycle strobes, at most one high per cycle, with no back-pressure;
// resp_busy and rx_active are levels. state exposes the receiver FSM.
interface lin_resp_hdr_rx_if;
  logic       sdi;
  logic [5:0] pid_out;
  logic       pid_valid;
  logic       sync_err;
  logic       frame_err;
  logic       parity_err;
  logic       resp_busy;
  logic       rx_active;
  logic [2:0] state;

  modport master (
    output sdi,
    input  pid_out, pid_valid, sync_err, frame_err, parity_err,
    input  resp_busy, rx_active, state
  );

  modport slave (
    input  sdi,
    output pid_out, pid_valid, sync_err, frame_err, parity_err,
    output resp_busy, rx_active, state
  );
endinterface

// File: rtl/lin_resp_hdr_rx.sv
// LIN header receiver: break detect, sync check, protected-ID decode and
// parity check, followed by a fixed-length response slot.
module lin_resp_hdr_rx #(
  parameter int BREAK_MIN = 13,
  parameter int RESP_SLOT = 20
) (
  input  logic             sys_clk,
  input  logic             rstn,
  lin_resp_hdr_rx_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_BREAK, S_SYNC, S_PID, S_GAP, S_PAR, S_STOP, S_RESP
  } state_t;

  localparam int RW = $clog2(RESP_SLOT + 1);
  // The zero counter saturates at 31, so a threshold above that can never match.
  localparam logic [5:0] BMIN = (BREAK_MIN > 32) ? 6'd32 : 6'(BREAK_MIN);

  state_t          state;
  state_t          state_nxt;
  logic [4:0]      zcnt;
  logic [3:0]      idx;
  logic [5:0]      id_sr;
  logic            p0;
  logic            p1;
  logic [RW-1:0]   rcnt;
  logic [5:0]      pid_q;
  logic            pv_q, se_q, fe_q, pe_q;
  logic            pv_nxt, se_nxt, fe_nxt, pe_nxt;

  logic brk_ok, sync_bad, par_ok, resp_done;

  assign brk_ok    = {1'b0, zcnt} >= BMIN;
  // Sync field alternates 0,1,0,1,... so the expected bit is the index LSB.
  assign sync_bad  = bus.sdi != idx[0];
  assign par_ok    = (p0 == (id_sr[0] ^ id_sr[1] ^ id_sr[2] ^ id_sr[4])) &&
                     (p1 == ~(id_sr[1] ^ id_sr[3] ^ id_sr[4] ^ id_sr[5]));
  assign resp_done = rcnt == RW'(RESP_SLOT - 1);

  // State register.
  always_ff @(posedge sys_clk) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode from the current state and the sampled line bit.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!bus.sdi) state_nxt = S_BREAK;
      S_BREAK: if (bus.sdi) state_nxt = brk_ok ? S_SYNC : S_IDLE;
      S_SYNC: begin
        if (sync_bad)          state_nxt = S_IDLE;
        else if (idx == 4'd9)  state_nxt = S_PID;
      end
      S_PID: begin
        if (idx == 4'd0 && bus.sdi) state_nxt = S_IDLE;
        else if (idx == 4'd6)       state_nxt = S_GAP;
      end
      S_GAP:   state_nxt = S_PAR;
      S_PAR:   if (idx[0]) state_nxt = S_STOP;
      S_STOP:  state_nxt = (bus.sdi && par_ok) ? S_RESP : S_IDLE;
      S_RESP:  if (resp_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Result strobes decided by the bit sampled at this edge.
  always_comb begin
    pv_nxt = 1'b0;
    se_nxt = 1'b0;
    fe_nxt = 1'b0;
    pe_nxt = 1'b0;
    case (state)
      S_SYNC: se_nxt = sync_bad;
      S_PID:  fe_nxt = (idx == 4'd0) && bus.sdi;
      S_STOP: begin
        fe_nxt = !bus.sdi;
        pv_nxt = bus.sdi && par_ok;
        pe_nxt = bus.sdi && !par_ok;
      end
      default: ;
    endcase
  end

  // Field counters, ID shift register, parity capture and registered results.
  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      zcnt  <= '0;
      idx   <= '0;
      id_sr <= '0;
      p0    <= 1'b0;
      p1    <= 1'b0;
      rcnt  <= '0;
      pid_q <= '0;
      pv_q  <= 1'b0;
      se_q  <= 1'b0;
      fe_q  <= 1'b0;
      pe_q  <= 1'b0;
    end else begin
      pv_q <= pv_nxt;
      se_q <= se_nxt;
      fe_q <= fe_nxt;
      pe_q <= pe_nxt;
      // Only a fully checked header reaches pid_out.
      if (pv_nxt) pid_q <= id_sr;
      case (state)
        S_IDLE:  zcnt <= 5'd1;
        S_BREAK: begin
          if (!bus.sdi && zcnt != 5'd31) zcnt <= zcnt + 5'd1;
          idx <= '0;
        end
        S_SYNC:  idx <= (idx == 4'd9) ? 4'd0 : idx + 4'd1;
        S_PID: begin
          if (idx != 4'd0) id_sr <= {bus.sdi, id_sr[5:1]};
          idx <= idx + 4'd1;
        end
        S_GAP:   idx <= '0;
        S_PAR: begin
          if (!idx[0]) p0 <= bus.sdi;
          else         p1 <= bus.sdi;
          idx <= idx + 4'd1;
        end
        S_STOP:  rcnt <= '0;
        S_RESP:  rcnt <= rcnt + RW'(1);
        default: ;
      endcase
    end
  end

  assign bus.pid_out    = pid_q;
  assign bus.pid_valid  = pv_q;
  assign bus.sync_err   = se_q;
  assign bus.frame_err  = fe_q;
  assign bus.parity_err = pe_q;
  assign bus.resp_busy  = state == S_RESP;
  assign bus.rx_active  = (state != S_IDLE) && (state != S_RESP);
  assign bus.state      = state;

endmodule

// File: tb/tb_lin_resp_hdr_rx.sv
// Bench for lin_resp_hdr_rx: directed LIN frames, a frame-level outcome model
// filling a per-edge expectation table, and a per-edge compare process.
module tb_lin_resp_hdr_rx;
  localparam int BREAK_MIN = 13;
  localparam int RESP_SLOT = 20;
  localparam int DEPTH     = 4096;
  localparam logic [9:0] SYNC_OK = 10'h2AA;

  localparam int K_NONE = 0, K_OK = 1, K_SYNC = 2, K_FRAME = 3, K_PAR = 4;

  // ---------------- clock / reset ----------------
  logic sys_clk = 1'b0;
  logic rstn    = 1'b0;
  always #5 sys_clk = ~sys_clk;

  lin_resp_hdr_rx_if bus();

  lin_resp_hdr_rx #(.BREAK_MIN(BREAK_MIN), .RESP_SLOT(RESP_SLOT)) dut (
    .sys_clk (sys_clk),
    .rstn    (rstn),
    .bus     (bus)
  );

  // ---------------- expectation table ----------------
  int         edge_no = 0;
  int         n_vec   = 0;
  int         n_err   = 0;
  logic       chk      [DEPTH];
  logic       exp_act  [DEPTH];
  logic       exp_pv   [DEPTH];
  logic       exp_se   [DEPTH];
  logic       exp_fe   [DEPTH];
  logic       exp_pe   [DEPTH];
  logic       exp_busy [DEPTH];
  logic [5:0] exp_pid  [DEPTH];
  logic [5:0] cur_pid = 6'h00;
  int         busy_run = 0;
  int         last_run = 0;

  initial begin
    for (int i = 0; i < DEPTH; i++) chk[i] = 1'b0;
  end

  task automatic cmp(string nm, int e, logic [5:0] got, logic [5:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s edge %0d: got %h want %h", nm, e, got, want);
    end
  endtask

  // ---------------- scoreboard compare ----------------
  always @(posedge sys_clk) begin
    edge_no++;
    #2;
    if (bus.resp_busy === 1'b1) busy_run++;
    else if (busy_run > 0) begin
      last_run = busy_run;
      busy_run = 0;
    end
    if (edge_no < DEPTH && chk[edge_no]) begin
      cmp("rx_active",  edge_no, {5'd0, bus.rx_active},  {5'd0, exp_act[edge_no]});
      cmp("pid_valid",  edge_no, {5'd0, bus.pid_valid},  {5'd0, exp_pv[edge_no]});
      cmp("sync_err",   edge_no, {5'd0, bus.sync_err},   {5'd0, exp_se[edge_no]});
      cmp("frame_err",  edge_no, {5'd0, bus.frame_err},  {5'd0, exp_fe[edge_no]});
      cmp("parity_err", edge_no, {5'd0, bus.parity_err}, {5'd0, exp_pe[edge_no]});
      cmp("resp_busy",  edge_no, {5'd0, bus.resp_busy},  {5'd0, exp_busy[edge_no]});
      cmp("pid_out",    edge_no, bus.pid_out,            exp_pid[edge_no]);
    end
  end

  // ---------------- driver tasks ----------------
  // Drive one bit (sampled at the next rising edge) and record what the
  // outputs must show after that edge.
  task automatic drive(logic b, logic r, logic act, logic pv, logic se,
                       logic fe, logic pe, logic busy);
    int e;
    @(negedge sys_clk);
    e = edge_no + 1;
    if (e < DEPTH) begin
      chk[e]      = 1'b1;
      exp_act[e]  = r & act;
      exp_pv[e]   = r & pv;
      exp_se[e]   = r & se;
      exp_fe[e]   = r & fe;
      exp_pe[e]   = r & pe;
      exp_busy[e] = r & busy;
      exp_pid[e]  = cur_pid;
    end
    bus.sdi = b;
    rstn    = r;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(int n);
    cur_pid = 6'h00;
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
  endtask

  // Frame-level model: find the bit that decides the frame and its outcome,
  // then send bits up to it. Outputs show the result one edge after that bit.
  task automatic frame(int nz, logic [9:0] sy, logic [6:0] pd, logic gp,
                       logic pa0, logic pa1, logic sp);
    logic q[$];
    int d;
    int kind;
    logic [5:0] id;
    logic want0, want1;
    id = pd[6:1];
    for (int i = 0; i < nz; i++) q.push_back(1'b0);
    q.push_back(1'b1);
    for (int j = 0; j < 10; j++) q.push_back(sy[j]);
    for (int j = 0; j < 7; j++) q.push_back(pd[j]);
    q.push_back(gp);
    q.push_back(pa0);
    q.push_back(pa1);
    q.push_back(sp);
    want0 = ^(id & 6'h17);
    want1 = ~^(id & 6'h3A);
    kind = K_NONE;
    d = nz;
    if (nz >= BREAK_MIN) begin
      d = -1;
      for (int j = 0; j < 10; j++)
        if (d < 0 && sy[j] != 1'(j % 2)) begin
          d = nz + 1 + j;
          kind = K_SYNC;
        end
      if (d < 0) begin
        if (pd[0] == 1'b1) begin d = nz + 11; kind = K_FRAME; end
        else begin
          d = nz + 21;
          if (!sp)                                  kind = K_FRAME;
          else if (pa0 != want0 || pa1 != want1)    kind = K_PAR;
          else                                      kind = K_OK;
        end
      end
    end
    for (int i = 0; i <= d; i++) begin
      if (i == d && kind == K_OK) cur_pid = id;
      drive(q[i], 1'b1, i < d,
            i == d && kind == K_OK, i == d && kind == K_SYNC,
            i == d && kind == K_FRAME, i == d && kind == K_PAR,
            i == d && kind == K_OK);
    end
    if (kind == K_OK)
      for (int k = 1; k <= RESP_SLOT; k++)
        drive(1'($urandom_range(0, 1)), 1'b1, 0, 0, 0, 0, 0, k < RESP_SLOT);
    idle(2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] stray;
    bus.sdi = 1'b1;
    do_reset(3);
    idle(3);

    // Good header, ID 0x3A.
    frame(13, SYNC_OK, {6'h3A, 1'b0}, 1'b1, 1'b0, 1'b1, 1'b1);
    cmp("lit_pid_3a", edge_no, bus.pid_out, 6'h3A);
    cmp("lit_busy_len", edge_no, 6'(last_run), 6'd20);

    // Same frame with P1 flipped: parity error, pid_out kept.
    frame(13, SYNC_OK, {6'h3A, 1'b0}, 1'b1, 1'b0, 1'b0, 1'b1);
    cmp("lit_pid_kept", edge_no, bus.pid_out, 6'h3A);

    // Short break is dropped, then a header for ID 0x00.
    frame(12, SYNC_OK, {6'h3A, 1'b0}, 1'b1, 1'b0, 1'b1, 1'b1);
    frame(13, SYNC_OK, 7'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    cmp("lit_pid_00", edge_no, bus.pid_out, 6'h00);

    // Sync bit 3 flipped, then a good header for ID 0x2C (P0=1, P1=1).
    frame(13, 10'h2A2, {6'h3A, 1'b0}, 1'b1, 1'b0, 1'b1, 1'b1);
    frame(13, SYNC_OK, {6'h2C, 1'b0}, 1'b1, 1'b1, 1'b1, 1'b1);
    cmp("lit_pid_2c", edge_no, bus.pid_out, 6'h2C);

    // Stop bit low, then PID start bit high.
    frame(13, SYNC_OK, {6'h3A, 1'b0}, 1'b1, 1'b0, 1'b1, 1'b0);
    frame(13, SYNC_OK, {6'h3A, 1'b1}, 1'b1, 1'b0, 1'b1, 1'b1);

    // Long break (counter saturates), gap bit low, ID 0x15 (P0=1, P1=0).
    frame(40, SYNC_OK, {6'h15, 1'b0}, 1'b0, 1'b1, 1'b0, 1'b1);
    cmp("lit_pid_15", edge_no, bus.pid_out, 6'h15);

    // Reset in the middle of the PID field.
    for (int i = 0; i < 13; i++) drive(1'b0, 1'b1, 1, 0, 0, 0, 0, 0);
    drive(1'b1, 1'b1, 1, 0, 0, 0, 0, 0);
    for (int j = 0; j < 10; j++) drive(SYNC_OK[j], 1'b1, 1, 0, 0, 0, 0, 0);
    drive(1'b0, 1'b1, 1, 0, 0, 0, 0, 0);
    drive(1'b0, 1'b1, 1, 0, 0, 0, 0, 0);
    drive(1'b1, 1'b1, 1, 0, 0, 0, 0, 0);
    do_reset(3);
    // Leftover ID bits, gap, parity and stop: short zero runs only.
    stray = 8'b1101_1110;
    for (int i = 0; i < 8; i++) drive(stray[i], 1'b1, ~stray[i], 0, 0, 0, 0, 0);
    cmp("lit_pid_rst", edge_no, bus.pid_out, 6'h00);
    idle(2);

    // A full new header is accepted after reset.
    frame(13, SYNC_OK, {6'h3A, 1'b0}, 1'b1, 1'b0, 1'b1, 1'b1);
    cmp("lit_pid_after", edge_no, bus.pid_out, 6'h3A);

    idle(3);
    @(negedge sys_clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
